// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if
// Bundles the producer streams and the fifo write port that meet at the
// fifo write arbiter. Signal suffixes are from the arbiter's point of view.
//   req_data_i   producer data, slice i = [i*DWIDTH +: DWIDTH]
//   req_valid_i  producer i has a word
//   req_ready_o  word i accepted when valid & ready
//   fifo_full_i  fifo full flag (backpressure)
//   fifo_wrreq_o fifo write request
//   fifo_data_o  fifo write data, zero when no write
//   grant_o      one-hot current owner, zero when idle
//   grant_id_o   index of current owner, zero when idle
//   busy_o       a grant is active
// Modports: master = producers/fifo side, slave = arbiter side.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DWIDTH  = 8,
   parameter int RIDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
   logic [NUM_REQ*DWIDTH-1:0] req_data_i;
   logic [NUM_REQ-1:0]        req_valid_i;
   logic [NUM_REQ-1:0]        req_ready_o;
   logic                      fifo_full_i;
   logic                      fifo_wrreq_o;
   logic [DWIDTH-1:0]         fifo_data_o;
   logic [NUM_REQ-1:0]        grant_o;
   logic [RIDW-1:0]           grant_id_o;
   logic                      busy_o;

   modport master (
      output req_data_i, req_valid_i, fifo_full_i,
      input  req_ready_o, fifo_wrreq_o, fifo_data_o, grant_o, grant_id_o, busy_o
   );

   modport slave (
      input  req_data_i, req_valid_i, fifo_full_i,
      output req_ready_o, fifo_wrreq_o, fifo_data_o, grant_o, grant_id_o, busy_o
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing one fifo write port between NUM_REQ producers.
// A grant lasts up to MAX_BURST words or until the owner drops valid; a full
// fifo stalls the burst but never ends it.
// Ports:
//   clk_i     clock
//   arst_n_i  asynchronous active-low reset
//   bus       fifo_wr_arbiter_if.slave (producer streams, fifo write port,
//             grant status)
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no owner; pick the next valid producer after last_q
// S_GRANT | owner_q drives the fifo until burst done or valid dropped
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DWIDTH    = 8,
   parameter int MAX_BURST = 4,
   parameter int RIDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input logic               clk_i,
   input logic               arst_n_i,
   fifo_wr_arbiter_if.slave  bus
);
   localparam int CW = $clog2(MAX_BURST + 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;

   localparam logic [RIDW-1:0] LAST_RST = RIDW'(NUM_REQ - 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(MAX_BURST - 1);

   logic [0:0]        state_q, state_d;
   logic [RIDW-1:0]   owner_q, owner_d;
   logic [RIDW-1:0]   last_q, last_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   logic              any_valid;
   logic [RIDW-1:0]   winner;
   logic              owner_valid;
   logic [DWIDTH-1:0] owner_data;
   logic              busy;
   logic              xfer;

   // Rotating priority: indices above last_q first, then wrap to the rest.
   always_comb begin
      any_valid = 1'b0;
      winner    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any_valid && bus.req_valid_i[i] && (RIDW'(i) > last_q)) begin
            any_valid = 1'b1;
            winner    = RIDW'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!any_valid && bus.req_valid_i[i] && (RIDW'(i) <= last_q)) begin
            any_valid = 1'b1;
            winner    = RIDW'(i);
         end
      end
   end

   always_comb begin
      owner_valid = 1'b0;
      owner_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == RIDW'(i)) begin
            owner_valid = bus.req_valid_i[i];
            owner_data  = bus.req_data_i[i*DWIDTH +: DWIDTH];
         end
      end
   end

   assign busy = (state_q == S_GRANT);
   assign xfer = busy && owner_valid && !bus.fifo_full_i;

   always_comb begin
      bus.grant_o     = '0;
      bus.req_ready_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (busy && (owner_q == RIDW'(i))) begin
            bus.grant_o[i]     = 1'b1;
            bus.req_ready_o[i] = !bus.fifo_full_i;
         end
      end
      bus.grant_id_o   = busy ? owner_q : '0;
      bus.busy_o       = busy;
      bus.fifo_wrreq_o = xfer;
      // Zeroed when idle so the fifo never sees stale or X data.
      bus.fifo_data_o  = xfer ? owner_data : '0;
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (any_valid) begin
               state_d = S_GRANT;
               owner_d = winner;
               cnt_d   = '0;
            end
         end
         S_GRANT: begin
            if (!owner_valid || (xfer && (cnt_q == CNT_LAST))) begin
               state_d = S_IDLE;
               last_d  = owner_q;
               owner_d = '0;
               cnt_d   = '0;
            end else if (xfer) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            owner_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q <= S_IDLE;
         owner_q <= '0;
         last_q  <= LAST_RST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Drives producer streams and a 16-deep fifo model around fifo_wr_arbiter.
// Producer words are tagged {id[1:0], seq[5:0]} so fifo contents identify
// both the source and the order.
module tb_fifo_wr_arbiter;
   localparam int NUM_REQ    = 4;
   localparam int DWIDTH     = 8;
   localparam int MAX_BURST  = 4;
   localparam int RIDW       = 2;
   localparam int FIFO_DEPTH = 16;

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DWIDTH(DWIDTH), .RIDW(RIDW)) bus ();

   fifo_wr_arbiter #(
      .NUM_REQ(NUM_REQ), .DWIDTH(DWIDTH), .MAX_BURST(MAX_BURST), .RIDW(RIDW)
   ) dut (
      .clk_i   (clk),
      .arst_n_i(arst_n),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;

   int prod_left [NUM_REQ];
   int prod_seq  [NUM_REQ];
   logic [DWIDTH-1:0] fifo_q[$];
   logic [DWIDTH-1:0] wr_log[$];
   logic fifo_rd = 1'b0;

   function automatic logic [DWIDTH-1:0] word_of(int p, int s);
      logic [1:0] pp;
      logic [5:0] ss;
      pp = p[1:0];
      ss = s[5:0];
      return {pp, ss};
   endfunction

   task automatic drive_inputs();
      for (int p = 0; p < NUM_REQ; p++) begin
         bus.req_valid_i[p] = (prod_left[p] > 0);
         bus.req_data_i[p*DWIDTH +: DWIDTH] = word_of(p, prod_seq[p]);
      end
      bus.fifo_full_i = (fifo_q.size() >= FIFO_DEPTH);
   endtask

   // One clock: sample handshakes at negedge, then update producers and fifo.
   task automatic advance();
      logic               c_wr, c_rd, rd_ok;
      logic [DWIDTH-1:0]  c_data;
      logic [NUM_REQ-1:0] c_valid, c_ready;
      @(negedge clk);
      c_wr    = bus.fifo_wrreq_o;
      c_data  = bus.fifo_data_o;
      c_valid = bus.req_valid_i;
      c_ready = bus.req_ready_o;
      c_rd    = fifo_rd;
      @(posedge clk);
      #1;
      for (int p = 0; p < NUM_REQ; p++) begin
         if (c_valid[p] && c_ready[p]) begin
            prod_seq[p]++;
            prod_left[p]--;
         end
      end
      rd_ok = c_rd && (fifo_q.size() > 0);
      if (c_wr) begin
         fifo_q.push_back(c_data);
         wr_log.push_back(c_data);
      end
      if (rd_ok) void'(fifo_q.pop_front());
      fifo_rd = 1'b0;
      drive_inputs();
   endtask

   task automatic do_reset();
      arst_n = 1'b0;
      for (int p = 0; p < NUM_REQ; p++) begin
         prod_left[p] = 0;
         prod_seq[p]  = 0;
      end
      fifo_q.delete();
      wr_log.delete();
      fifo_rd = 1'b0;
      drive_inputs();
      advance();
      advance();
      arst_n = 1'b1;
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      for (int p = 0; p < NUM_REQ; p++) prod_left[p] = 5;
      drive_inputs();
      #2;
      checks++; if (bus.grant_o !== 4'b0000) begin failures++; $display("FAIL reset_grant actual=%b expected=0000", bus.grant_o); end
      checks++; if (bus.grant_id_o !== 2'd0) begin failures++; $display("FAIL reset_grant_id actual=%0d expected=0", bus.grant_id_o); end
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b expected=0", bus.busy_o); end
      checks++; if (bus.req_ready_o !== 4'b0000) begin failures++; $display("FAIL reset_ready actual=%b expected=0000", bus.req_ready_o); end
      checks++; if (bus.fifo_wrreq_o !== 1'b0) begin failures++; $display("FAIL reset_wrreq actual=%b expected=0", bus.fifo_wrreq_o); end
      checks++; if (bus.fifo_data_o !== 8'h00) begin failures++; $display("FAIL reset_data actual=%h expected=00", bus.fifo_data_o); end
      advance();
      advance();
      #1;
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_held_busy actual=%b expected=0", bus.busy_o); end
      checks++; if (bus.fifo_wrreq_o !== 1'b0) begin failures++; $display("FAIL reset_held_wrreq actual=%b expected=0", bus.fifo_wrreq_o); end
   endtask

   task automatic test_single_burst();
      bit exp_busy [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
      bit exp_wr   [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
      logic [NUM_REQ-1:0] eg;
      do_reset();
      prod_left[0] = 6;
      drive_inputs();
      for (int c = 0; c < 10; c++) begin
         #1;
         eg = exp_busy[c] ? 4'b0001 : 4'b0000;
         checks++; if (bus.busy_o !== exp_busy[c]) begin failures++; $display("FAIL single_busy c=%0d actual=%b expected=%b", c, bus.busy_o, exp_busy[c]); end
         checks++; if (bus.fifo_wrreq_o !== exp_wr[c]) begin failures++; $display("FAIL single_wrreq c=%0d actual=%b expected=%b", c, bus.fifo_wrreq_o, exp_wr[c]); end
         checks++; if (bus.grant_o !== eg) begin failures++; $display("FAIL single_grant c=%0d actual=%b expected=%b", c, bus.grant_o, eg); end
         advance();
      end
      checks++; if (fifo_q.size() != 6) begin failures++; $display("FAIL single_usedw actual=%0d expected=6", fifo_q.size()); end
      for (int k = 0; k < 6 && k < fifo_q.size(); k++) begin
         checks++; if (fifo_q[k] !== word_of(0, k)) begin failures++; $display("FAIL single_order k=%0d actual=%h expected=%h", k, fifo_q[k], word_of(0, k)); end
      end
   endtask

   task automatic test_round_robin();
      logic [NUM_REQ-1:0] eg;
      bit exp_b;
      int eid;
      do_reset();
      for (int p = 0; p < NUM_REQ; p++) prod_left[p] = 8;
      drive_inputs();
      for (int c = 0; c < 25; c++) begin
         fifo_rd = 1'b1;
         #1;
         exp_b = (c % 5) != 0;
         eid   = (c / 5) % NUM_REQ;
         eg    = '0;
         if (exp_b) eg[eid] = 1'b1;
         checks++; if (bus.busy_o !== exp_b) begin failures++; $display("FAIL rr_busy c=%0d actual=%b expected=%b", c, bus.busy_o, exp_b); end
         checks++; if (bus.fifo_wrreq_o !== exp_b) begin failures++; $display("FAIL rr_wrreq c=%0d actual=%b expected=%b", c, bus.fifo_wrreq_o, exp_b); end
         checks++; if (bus.grant_o !== eg) begin failures++; $display("FAIL rr_grant c=%0d actual=%b expected=%b", c, bus.grant_o, eg); end
         if (exp_b) begin
            checks++; if (int'(bus.grant_id_o) != eid) begin failures++; $display("FAIL rr_grant_id c=%0d actual=%0d expected=%0d", c, bus.grant_id_o, eid); end
         end
         advance();
      end
      checks++; if (wr_log.size() != 20) begin failures++; $display("FAIL rr_count actual=%0d expected=20", wr_log.size()); end
      for (int k = 0; k < 16 && k < wr_log.size(); k++) begin
         checks++; if (wr_log[k] !== word_of(k / 4, k % 4)) begin failures++; $display("FAIL rr_group k=%0d actual=%h expected=%h", k, wr_log[k], word_of(k / 4, k % 4)); end
      end
   endtask

   task automatic test_full_backpressure();
      do_reset();
      for (int k = 0; k < 13; k++) fifo_q.push_back(8'hFF);
      prod_left[2] = 20;
      drive_inputs();
      #1;
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL full_idle0 actual=%b expected=0", bus.busy_o); end
      advance();
      prod_left[1] = 10;
      drive_inputs();
      for (int c = 1; c < 4; c++) begin
         #1;
         checks++; if (bus.grant_o !== 4'b0100) begin failures++; $display("FAIL full_grant c=%0d actual=%b expected=0100", c, bus.grant_o); end
         checks++; if (bus.fifo_wrreq_o !== 1'b1) begin failures++; $display("FAIL full_fill_wr c=%0d actual=%b expected=1", c, bus.fifo_wrreq_o); end
         advance();
      end
      for (int c = 4; c < 7; c++) begin
         #1;
         checks++; if (bus.fifo_wrreq_o !== 1'b0) begin failures++; $display("FAIL full_stall_wr c=%0d actual=%b expected=0", c, bus.fifo_wrreq_o); end
         checks++; if (bus.grant_o !== 4'b0100) begin failures++; $display("FAIL full_hold_grant c=%0d actual=%b expected=0100", c, bus.grant_o); end
         checks++; if (bus.req_ready_o !== 4'b0000) begin failures++; $display("FAIL full_ready c=%0d actual=%b expected=0000", c, bus.req_ready_o); end
         if (c == 6) fifo_rd = 1'b1;
         advance();
      end
      #1;
      checks++; if (bus.fifo_wrreq_o !== 1'b1) begin failures++; $display("FAIL full_resume_wr actual=%b expected=1", bus.fifo_wrreq_o); end
      checks++; if (bus.fifo_data_o !== word_of(2, 3)) begin failures++; $display("FAIL full_resume_data actual=%h expected=%h", bus.fifo_data_o, word_of(2, 3)); end
      advance();
      #1;
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL full_release actual=%b expected=0", bus.busy_o); end
      advance();
      #1;
      checks++; if (bus.grant_o !== 4'b0010) begin failures++; $display("FAIL full_next_grant actual=%b expected=0010", bus.grant_o); end
      checks++; if (bus.fifo_wrreq_o !== 1'b0) begin failures++; $display("FAIL full_next_wr actual=%b expected=0", bus.fifo_wrreq_o); end
      checks++; if (wr_log.size() != 4) begin failures++; $display("FAIL full_write_count actual=%0d expected=4", wr_log.size()); end
   endtask

   task automatic test_valid_drop();
      do_reset();
      prod_left[3] = 2;
      drive_inputs();
      advance();
      for (int c = 1; c < 3; c++) begin
         #1;
         checks++; if (bus.fifo_wrreq_o !== 1'b1) begin failures++; $display("FAIL drop_wr c=%0d actual=%b expected=1", c, bus.fifo_wrreq_o); end
         advance();
      end
      #1;
      checks++; if (bus.grant_o !== 4'b1000) begin failures++; $display("FAIL drop_grant_held actual=%b expected=1000", bus.grant_o); end
      checks++; if (bus.fifo_wrreq_o !== 1'b0) begin failures++; $display("FAIL drop_no_wr actual=%b expected=0", bus.fifo_wrreq_o); end
      advance();
      prod_left[0] = 1;
      prod_left[2] = 1;
      prod_left[3] = 2;
      drive_inputs();
      #1;
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL drop_idle actual=%b expected=0", bus.busy_o); end
      advance();
      #1;
      checks++; if (bus.grant_o !== 4'b0001) begin failures++; $display("FAIL drop_wrap_grant actual=%b expected=0001", bus.grant_o); end
      checks++; if (bus.grant_id_o !== 2'd0) begin failures++; $display("FAIL drop_wrap_id actual=%0d expected=0", bus.grant_id_o); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      prod_left[1] = 20;
      drive_inputs();
      advance();
      advance();
      advance();
      #1;
      checks++; if (bus.grant_o !== 4'b0010) begin failures++; $display("FAIL midrst_pre_grant actual=%b expected=0010", bus.grant_o); end
      arst_n = 1'b0;
      for (int p = 0; p < NUM_REQ; p++) prod_left[p] = 20;
      drive_inputs();
      #1;
      checks++; if (bus.grant_o !== 4'b0000) begin failures++; $display("FAIL midrst_grant actual=%b expected=0000", bus.grant_o); end
      checks++; if (bus.grant_id_o !== 2'd0) begin failures++; $display("FAIL midrst_id actual=%0d expected=0", bus.grant_id_o); end
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy actual=%b expected=0", bus.busy_o); end
      checks++; if (bus.req_ready_o !== 4'b0000) begin failures++; $display("FAIL midrst_ready actual=%b expected=0000", bus.req_ready_o); end
      checks++; if (bus.fifo_wrreq_o !== 1'b0) begin failures++; $display("FAIL midrst_wr actual=%b expected=0", bus.fifo_wrreq_o); end
      checks++; if (bus.fifo_data_o !== 8'h00) begin failures++; $display("FAIL midrst_data actual=%h expected=00", bus.fifo_data_o); end
      advance();
      advance();
      arst_n = 1'b1;
      #1;
      checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL midrst_idle actual=%b expected=0", bus.busy_o); end
      advance();
      #1;
      checks++; if (bus.grant_o !== 4'b0001) begin failures++; $display("FAIL midrst_first_grant actual=%b expected=0001", bus.grant_o); end
      checks++; if (bus.fifo_wrreq_o !== 1'b1) begin failures++; $display("FAIL midrst_first_wr actual=%b expected=1", bus.fifo_wrreq_o); end
   endtask

   // Reference: owner index (-1 when idle), words moved in this grant, last
   // owner. Expected outputs are derived from these and the driven inputs.
   task automatic test_random();
      int m_owner, m_cnt, m_last, exp_next[NUM_REQ], total, pid;
      bit found, e_wr, full;
      logic [NUM_REQ-1:0] v, eg, er;
      logic [RIDW-1:0] eid;
      logic [DWIDTH-1:0] ed;
      do_reset();
      m_owner = -1;
      m_cnt   = 0;
      m_last  = NUM_REQ - 1;
      for (int p = 0; p < NUM_REQ; p++) exp_next[p] = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         for (int p = 0; p < NUM_REQ; p++)
            if (prod_left[p] == 0 && $urandom_range(0, 3) == 0) prod_left[p] = int'($urandom_range(1, 6));
         fifo_rd = ($urandom_range(0, 2) == 0);
         drive_inputs();
         #1;
         v    = bus.req_valid_i;
         full = bus.fifo_full_i;
         eg   = '0;
         er   = '0;
         eid  = '0;
         e_wr = 1'b0;
         ed   = '0;
         if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            er[m_owner] = !full;
            eid  = m_owner[RIDW-1:0];
            e_wr = v[m_owner] && !full;
            if (e_wr) ed = word_of(m_owner, prod_seq[m_owner]);
         end
         checks++; if (bus.grant_o !== eg) begin failures++; $display("FAIL rand_grant cyc=%0d actual=%b expected=%b", cyc, bus.grant_o, eg); end
         checks++; if (bus.grant_id_o !== eid) begin failures++; $display("FAIL rand_grant_id cyc=%0d actual=%0d expected=%0d", cyc, bus.grant_id_o, eid); end
         checks++; if (bus.busy_o !== (m_owner >= 0)) begin failures++; $display("FAIL rand_busy cyc=%0d actual=%b expected=%b", cyc, bus.busy_o, (m_owner >= 0)); end
         checks++; if (bus.req_ready_o !== er) begin failures++; $display("FAIL rand_ready cyc=%0d actual=%b expected=%b", cyc, bus.req_ready_o, er); end
         checks++; if (bus.fifo_wrreq_o !== e_wr) begin failures++; $display("FAIL rand_wrreq cyc=%0d actual=%b expected=%b", cyc, bus.fifo_wrreq_o, e_wr); end
         checks++; if (bus.fifo_data_o !== ed) begin failures++; $display("FAIL rand_data cyc=%0d actual=%h expected=%h", cyc, bus.fifo_data_o, ed); end
         checks++; if (bus.fifo_wrreq_o === 1'b1 && full) begin failures++; $display("FAIL rand_wr_when_full cyc=%0d actual=1 expected=0", cyc); end
         checks++; if (!$onehot0(bus.grant_o)) begin failures++; $display("FAIL rand_onehot cyc=%0d actual=%b expected=onehot0", cyc, bus.grant_o); end
         if (bus.fifo_wrreq_o === 1'b1) begin
            pid = int'(bus.fifo_data_o[7:6]);
            checks++;
            if (bus.fifo_data_o !== word_of(pid, exp_next[pid])) begin
               failures++;
               $display("FAIL rand_sequence cyc=%0d actual=%h expected=%h", cyc, bus.fifo_data_o, word_of(pid, exp_next[pid]));
            end
            exp_next[pid]++;
         end
         if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
               if (!found && v[(m_last + k) % NUM_REQ]) begin
                  found   = 1'b1;
                  m_owner = (m_last + k) % NUM_REQ;
                  m_cnt   = 0;
               end
            end
         end else begin
            if (e_wr) m_cnt++;
            if (!v[m_owner] || m_cnt == MAX_BURST) begin
               m_last  = m_owner;
               m_owner = -1;
               m_cnt   = 0;
            end
         end
         advance();
      end
      total = 0;
      for (int p = 0; p < NUM_REQ; p++) begin
         total += prod_seq[p];
         checks++; if (exp_next[p] != prod_seq[p]) begin failures++; $display("FAIL rand_lost_dup p=%0d actual=%0d expected=%0d", p, exp_next[p], prod_seq[p]); end
      end
      checks++; if (wr_log.size() != total) begin failures++; $display("FAIL rand_total actual=%0d expected=%0d", wr_log.size(), total); end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_round_robin();
      test_full_backpressure();
      test_valid_drop();
      test_mid_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
